// File: rtl/mul_unit.sv
// Iterative signed WIDTH x WIDTH -> 2*WIDTH multiplier, one shift-add step per clock.
// Fixed latency WIDTH+1 edges from accepted start to done; start is ignored while busy, and requests are not queued.
module mul_unit #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mul1,
  input  logic [WIDTH-1:0]     mul2,
  output logic [2*WIDTH-1:0]   mulresult,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]      LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0]   ONE1 = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2 = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic               w_load;
  logic               w_step;
  logic               w_fix;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [2*WIDTH-1:0] w_addend;

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_result;
  logic               r_busy;
  logic               r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      S_IDLE:  w_load = start;
      S_RUN:   w_step = 1'b1;
      S_FIX:   w_fix  = 1'b1;
      default: ;
    endcase
  end

  // Magnitudes as unsigned: the most negative operand maps to 2^(WIDTH-1) without overflow.
  assign w_abs1   = mul1[WIDTH-1] ? (~mul1 + ONE1) : mul1;
  assign w_abs2   = mul2[WIDTH-1] ? (~mul2 + ONE1) : mul2;
  assign w_addend = {{WIDTH{1'b0}}, r_mcand} << r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_load) begin
        r_mcand  <= w_abs1;
        r_mplier <= w_abs2;
        r_neg    <= mul1[WIDTH-1] ^ mul2[WIDTH-1];
        r_acc    <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end
      if (w_step) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + w_addend;
        end
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_ONE;
      end
      if (w_fix) begin
        r_result <= r_neg ? (~r_acc + ONE2) : r_acc;
        r_busy   <= 1'b0;
      end
    end
  end

  assign mulresult = r_result;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: directed vector table, busy/abort/back-to-back sequences,
// and random operands compared against a plain-arithmetic product model.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] mul1;
  logic [15:0] mul2;
  logic [31:0] mulresult;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          failures = 0;
  int          disturb_at = -1;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  mul_unit #(.WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mul1(mul1),
    .mul2(mul2),
    .mulresult(mulresult),
    .busy(busy),
    .done(done)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_mul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  // Entered #1 after the edge that accepted start; returns #1 after the done edge.
  task automatic wait_done(input logic [31:0] hold_val, output int lat, output int bcnt,
                           output int bad_hold, output int both);
    bit got;
    got      = 1'b0;
    lat      = 0;
    bad_hold = 0;
    both     = 0;
    bcnt     = busy ? 1 : 0;
    if (mulresult !== hold_val) bad_hold++;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == disturb_at) begin
        start = 1'b1;
        mul1  = 16'd9;
        mul2  = 16'd9;
      end else begin
        start = 1'b0;
      end
      if (busy && done) both++;
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) bcnt++;
        if (mulresult !== hold_val) bad_hold++;
      end
    end
  endtask

  task automatic finish_op(input logic [31:0] exp, input string name);
    int lat, bcnt, bad_hold, both;
    wait_done(last_res, lat, bcnt, bad_hold, both);
    check({name, " latency"}, lat, 32'd17);
    check({name, " busy_cycles"}, bcnt, 32'd17);
    check({name, " result"}, mulresult, exp);
    check({name, " hold_prev"}, bad_hold, 32'd0);
    check({name, " busy_and_done"}, both, 32'd0);
    last_res   = exp;
    disturb_at = -1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                        input string name, input bit disturb);
    @(negedge clk);
    mul1  = a;
    mul2  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (disturb) begin
      mul1       = 16'h1234;
      mul2       = 16'h4321;
      disturb_at = 5;
    end
    finish_op(exp, name);
  endtask

  initial begin
    vec_t vecs[7];
    int   extra;

    vecs[0] = '{16'd3,    16'd5,    32'h0000000F};
    vecs[1] = '{16'hFFF9, 16'd6,    32'hFFFFFFD6};
    vecs[2] = '{16'd0,    16'hFFFF, 32'h00000000};
    vecs[3] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[4] = '{16'h7FFF, 16'h8000, 32'hC0008000};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[6] = '{16'h8000, 16'd1,    32'hFFFF8000};

    reset = 1'b1;
    start = 1'b0;
    mul1  = '0;
    mul2  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset mulresult", mulresult, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle done", {31'd0, done}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);
    end

    // Start pulsed mid-run and operands changed after capture: one done only.
    run_op(16'd100, 16'd200, 32'h00004E20, "busy_ignore", 1'b1);
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("busy_ignore extra_done", extra, 32'd0);

    // Back-to-back: new start raised in the done cycle.
    run_op(16'd7, 16'd8, 32'd56, "b2b_first", 1'b0);
    mul1  = 16'd2;
    mul2  = 16'hFFFD;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_op(32'hFFFFFFFA, "b2b_second");

    for (int i = 0; i < 30; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 0) a = 16'h8000;
      if (i == 1) b = 16'h0001;
      run_op(a, b, model_mul(a, b), $sformatf("rand%0d a=%04h b=%04h", i, a, b), 1'b0);
    end

    // Abort in the middle of RUN.
    @(negedge clk);
    mul1  = 16'd12345;
    mul2  = 16'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort mulresult", mulresult, 32'd0);
    extra = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("abort no_done", extra, 32'd0);
    last_res = '0;
    run_op(16'd4, 16'd4, 32'h00000010, "after_abort", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
